// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word fetches, buffers DEPTH entries.
// Optional same-cycle ack-to-output bypass when empty: define IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_CNT1  = CW'(1);
    localparam logic [PW-1:0] L_PTR1  = PW'(1);

    logic [31:0]   r_fpc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_drop;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_pc_q    [DEPTH];
    logic [31:0]   r_instr_q [DEPTH];

    logic          w_accept;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_fpc_n;
    logic [CW-1:0] w_count_n;
    logic [PW-1:0] w_wr_ptr_n;
    logic [PW-1:0] w_rd_ptr_n;
    logic          w_drop_n;
    logic          w_req_n;
    logic [31:0]   w_addr_n;
    logic          w_unused;

    assign w_unused = ^redirect_pc[1:0];

    always_comb begin
        w_accept = r_req && im_ack;
        w_bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
        w_bypass = w_accept && !r_drop && !redirect && (r_count == '0);
`endif
        w_pop  = (r_count != '0) && out_ready && !redirect;
        w_push = w_accept && !r_drop && !redirect && !(w_bypass && out_ready);

        w_fpc_n = r_fpc;
        if (redirect)
            w_fpc_n = {redirect_pc[31:2], 2'b00};
        else if (w_accept && !r_drop)
            w_fpc_n = r_fpc + 32'd4;

        w_count_n  = r_count;
        w_wr_ptr_n = r_wr_ptr;
        w_rd_ptr_n = r_rd_ptr;
        if (redirect) begin
            w_count_n  = '0;
            w_wr_ptr_n = '0;
            w_rd_ptr_n = '0;
        end else begin
            if (w_push && !w_pop)
                w_count_n = r_count + L_CNT1;
            else if (!w_push && w_pop)
                w_count_n = r_count - L_CNT1;
            if (w_push)
                w_wr_ptr_n = r_wr_ptr + L_PTR1;
            if (w_pop)
                w_rd_ptr_n = r_rd_ptr + L_PTR1;
        end

        // An unacked request must complete at its original address.
        if (r_req && !im_ack) begin
            w_req_n  = 1'b1;
            w_addr_n = r_addr;
            w_drop_n = r_drop || redirect;
        end else begin
            w_drop_n = 1'b0;
            w_req_n  = (w_count_n < L_DEPTH);
            w_addr_n = w_fpc_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc    <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
        end else begin
            r_fpc    <= w_fpc_n;
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_drop   <= w_drop_n;
            r_req    <= w_req_n;
            r_addr   <= w_addr_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_q[i]    <= '0;
                r_instr_q[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_q[r_wr_ptr]    <= r_fpc;
            r_instr_q[r_wr_ptr] <= im_rdata;
        end
    end

    assign im_req  = r_req;
    assign im_addr = r_addr;

`ifdef IFQ_BYPASS_EN
    assign out_valid = (r_count != '0) || w_bypass;
    assign out_instr = w_bypass ? im_rdata : r_instr_q[r_rd_ptr];
    assign out_pc    = w_bypass ? r_fpc : r_pc_q[r_rd_ptr];
`else
    assign out_valid = (r_count != '0);
    assign out_instr = r_instr_q[r_rd_ptr];
    assign out_pc    = r_pc_q[r_rd_ptr];
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirects, reset.
// Bypass scenario runs only when IFQ_BYPASS_EN is defined.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    logic        zw;
    logic        ack_drv;
    logic [31:0] rdata_drv;

    int total;
    int bad;

    assign im_ack   = zw ? im_req : ack_drv;
    assign im_rdata = zw ? im_addr : rdata_drv;

    instr_fetch_queue #(
        .DEPTH(4),
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .im_req(im_req),
        .im_addr(im_addr),
        .im_ack(im_ack),
        .im_rdata(im_rdata),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (im_req !== 1'b0) begin
            bad++; $display("FAIL rst_req got=%0b exp=0", im_req);
        end
        total++;
        if (im_addr !== 32'h3000) begin
            bad++; $display("FAIL rst_addr got=%h exp=00003000", im_addr);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid);
        end
        total++;
        if (out_instr !== 32'h0) begin
            bad++; $display("FAIL rst_instr got=%h exp=0", out_instr);
        end
        total++;
        if (out_pc !== 32'h0) begin
            bad++; $display("FAIL rst_pc got=%h exp=0", out_pc);
        end
        rst = 1'b1;
        tick();
        total++;
        if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
            bad++;
            $display("FAIL first_fetch got=%0b/%h exp=1/00003000",
                     im_req, im_addr);
        end
    endtask

    task automatic test_stream();
        zw = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (im_req !== 1'b1 || im_addr !== 32'h3000 + 32'(4 * i)) begin
                bad++;
                $display("FAIL stream_addr%0d got=%0b/%h exp=1/%h",
                         i, im_req, im_addr, 32'h3000 + 32'(4 * i));
            end
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 ||
                    out_pc !== 32'h3000 + 32'(4 * (i - 1)) ||
                    out_instr !== out_pc) begin
                    bad++;
                    $display("FAIL stream_out%0d got=%0b/%h/%h exp pc=%h",
                             i, out_valid, out_pc, out_instr,
                             32'h3000 + 32'(4 * (i - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acks;
        acks = 0;
        zw = 1'b1;
        out_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (im_req && im_ack) acks++;
            tick();
        end
        total++;
        if (acks != 4) begin
            bad++; $display("FAIL bp_acks got=%0d exp=4", acks);
        end
        total++;
        if (im_req !== 1'b0) begin
            bad++; $display("FAIL bp_req got=%0b exp=0", im_req);
        end
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin
            bad++;
            $display("FAIL bp_head got=%0b/%h exp=1/00003000",
                     out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * i)) begin
                bad++;
                $display("FAIL bp_drain%0d got=%0b/%h exp=1/%h",
                         i, out_valid, out_pc, 32'h3000 + 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_latency_redirect();
        zw = 1'b0;
        ack_drv = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            ack_drv = 1'b1;
            rdata_drv = 32'hA000_0000 + 32'(k);
            tick();
            ack_drv = 1'b0;
        end
        total++;
        if (im_req !== 1'b1 || im_addr !== 32'h3008) begin
            bad++;
            $display("FAIL lat_issue got=%0b/%h exp=1/00003008",
                     im_req, im_addr);
        end
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_4001;
        tick();
        redirect = 1'b0;
        total++;
        if (im_req !== 1'b1 || im_addr !== 32'h3008 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_hold got=%0b/%h/%0b exp=1/00003008/0",
                     im_req, im_addr, out_valid);
        end
        ack_drv = 1'b1;
        rdata_drv = 32'hDEAD_BEEF;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL lat_ackcyc got=%0b exp=0", out_valid);
        end
        tick();
        ack_drv = 1'b0;
        total++;
        if (im_req !== 1'b1 || im_addr !== 32'h4000 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_new got=%0b/%h/%0b exp=1/00004000/0",
                     im_req, im_addr, out_valid);
        end
        ack_drv = 1'b1;
        rdata_drv = 32'h1111_2222;
        tick();
        ack_drv = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4000 ||
            out_instr !== 32'h1111_2222) begin
            bad++;
            $display("FAIL lat_out got=%0b/%h/%h exp=1/00004000/11112222",
                     out_valid, out_pc, out_instr);
        end
        tick();
    endtask

    task automatic test_redirect_ack_pop();
        zw = 1'b0;
        out_ready = 1'b0;
        apply_reset();
        ack_drv = 1'b1;
        rdata_drv = 32'hAAAA_0000;
        tick();
        rdata_drv = 32'hAAAA_0001;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000 || im_addr !== 32'h3008) begin
            bad++;
            $display("FAIL rap_setup got=%0b/%h/%h exp=1/00003000/00003008",
                     out_valid, out_pc, im_addr);
        end
        rdata_drv = 32'hAAAA_0002;
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_5002;
        tick();
        redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h5000) begin
            bad++;
            $display("FAIL rap_after got=%0b/%0b/%h exp=0/1/00005000",
                     out_valid, im_req, im_addr);
        end
        rdata_drv = 32'hBBBB_0000;
        tick();
        ack_drv = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h5000 ||
            out_instr !== 32'hBBBB_0000) begin
            bad++;
            $display("FAIL rap_new got=%0b/%h/%h exp=1/00005000/bbbb0000",
                     out_valid, out_pc, out_instr);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || im_addr !== 32'h5004) begin
            bad++;
            $display("FAIL rap_nostale got=%0b/%h exp=0/00005004",
                     out_valid, im_addr);
        end
    endtask

    task automatic test_reset_mid();
        zw = 1'b0;
        ack_drv = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (im_req !== 1'b0 || im_addr !== 32'h3000 || out_valid !== 1'b0 ||
            out_pc !== 32'h0 || out_instr !== 32'h0) begin
            bad++;
            $display("FAIL rmid_now got=%0b/%h/%0b/%h/%h exp=0/00003000/0/0/0",
                     im_req, im_addr, out_valid, out_pc, out_instr);
        end
        ack_drv = 1'b1;
        rdata_drv = 32'hCCCC_CCCC;
        tick();
        total++;
        if (im_req !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_lateack got=%0b/%0b exp=0/0", im_req, out_valid);
        end
        ack_drv = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
            bad++;
            $display("FAIL rmid_restart got=%0b/%h exp=1/00003000",
                     im_req, im_addr);
        end
    endtask

`ifdef IFQ_BYPASS_EN
    task automatic test_bypass();
        zw = 1'b0;
        ack_drv = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        ack_drv = 1'b1;
        rdata_drv = 32'h2408_0005;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h2408_0005 ||
            out_pc !== 32'h3000) begin
            bad++;
            $display("FAIL byp_same got=%0b/%h/%h exp=1/24080005/00003000",
                     out_valid, out_instr, out_pc);
        end
        tick();
        ack_drv = 1'b0;
        total++;
        if (out_valid !== 1'b0 || im_addr !== 32'h3004) begin
            bad++;
            $display("FAIL byp_empty got=%0b/%h exp=0/00003004",
                     out_valid, im_addr);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        zw = 1'b0;
        ack_drv = 1'b0;
        rdata_drv = '0;
        repeat (2) @(posedge clk);
        test_reset();
`ifdef IFQ_BYPASS_EN
        test_bypass();
`else
        test_stream();
        test_backpressure();
        test_latency_redirect();
        test_redirect_ack_pop();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
